// File: rtl/msf_input_conditioner.sv
// MSF receiver front end: synchroniser, polarity fix, integrating deglitcher, 1 s edge cadence tracking and lock.
// Optional error statistics on err_count_o are enabled by defining MSF_INPUT_STATS_EN.
module msf_input_conditioner #(
  parameter int unsigned CLK_HZ     = 10000,
  parameter int unsigned FILT_MAX   = 15,
  parameter int unsigned LOCK_COUNT = 3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       data_i,
  input  logic       inverted_i,
  output logic       data_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic       sec_pulse_o,
  output logic       lock_o,
  output logic [7:0] err_count_o
);

  localparam int unsigned PERIOD_MIN = CLK_HZ - CLK_HZ / 10;
  localparam int unsigned PERIOD_MAX = CLK_HZ + CLK_HZ / 10;
  localparam int unsigned TIMEOUT    = 2 * CLK_HZ;
  localparam int unsigned PER_W      = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W      = $clog2(FILT_MAX + 1);
  localparam int unsigned GOOD_W     = $clog2(LOCK_COUNT + 1);

  localparam logic [PER_W-1:0]  P_MIN  = PER_W'(PERIOD_MIN);
  localparam logic [PER_W-1:0]  P_MAX  = PER_W'(PERIOD_MAX);
  localparam logic [PER_W-1:0]  P_TO   = PER_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  F_TOP  = CNT_W'(FILT_MAX);
  localparam logic [GOOD_W-1:0] G_TOP  = GOOD_W'(LOCK_COUNT);

  logic              s1;
  logic              s2;
  logic              raw;
  logic [CNT_W-1:0]  cnt;
  logic              data_d;
  logic [PER_W-1:0]  per_cnt;
  logic [GOOD_W-1:0] good_cnt;
  logic              edge_good;
  logic              edge_bad;
  logic              timeout_hit;

  assign raw = s2 ^ inverted_i;

  // Synchroniser, saturating integrator with hysteresis output, and edge detect
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      data_o <= 1'b0;
      data_d <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      s1 <= data_i;
      s2 <= s1;
      if (raw && (cnt != F_TOP)) begin
        cnt <= cnt + CNT_W'(1);
      end else if (!raw && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (cnt == F_TOP) begin
        data_o <= 1'b1;
      end else if (cnt == '0) begin
        data_o <= 1'b0;
      end
      data_d <= data_o;
      rise_o <= data_o & ~data_d;
      fall_o <= ~data_o & data_d;
    end
  end

  // Classify each rising edge against the running period; early edges are in-second bits
  assign edge_good   = rise_o && (per_cnt >= P_MIN) && (per_cnt <= P_MAX);
  assign edge_bad    = rise_o && (per_cnt > P_MAX);
  assign timeout_hit = !rise_o && (per_cnt == (P_TO - PER_W'(1)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      per_cnt     <= '0;
      good_cnt    <= '0;
      sec_pulse_o <= 1'b0;
      lock_o      <= 1'b0;
    end else begin
      sec_pulse_o <= edge_good | edge_bad;
      if (edge_good || edge_bad) begin
        per_cnt <= '0;
      end else if (per_cnt != P_TO) begin
        per_cnt <= per_cnt + PER_W'(1);
      end
      if (edge_bad || timeout_hit) begin
        good_cnt <= '0;
      end else if (edge_good && (good_cnt != G_TOP)) begin
        good_cnt <= good_cnt + GOOD_W'(1);
      end
      lock_o <= (good_cnt == G_TOP) && !(edge_bad || timeout_hit);
    end
  end

`ifdef MSF_INPUT_STATS_EN
  logic       err_evt;
  logic [7:0] err_q;

  // A late edge after a timeout was already counted by the timeout itself
  assign err_evt = timeout_hit || (edge_bad && (per_cnt != P_TO));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 8'h00;
    end else if (err_evt && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign err_count_o = err_q;
`else
  assign err_count_o = 8'h00;
`endif

endmodule

// File: tb/tb_msf_input_conditioner.sv
// Directed bench for msf_input_conditioner at CLK_HZ=100, FILT_MAX=3 (periods 90..110, timeout 200).
// Build with MSF_INPUT_STATS_EN to also check the error counter increments.
module tb_msf_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       data_i;
  logic       inverted_i;
  logic       data_o;
  logic       rise_o;
  logic       fall_o;
  logic       sec_pulse_o;
  logic       lock_o;
  logic [7:0] err_count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  msf_input_conditioner #(.CLK_HZ(100), .FILT_MAX(3), .LOCK_COUNT(3)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .data_i(data_i), .inverted_i(inverted_i),
    .data_o(data_o), .rise_o(rise_o), .fall_o(fall_o), .sec_pulse_o(sec_pulse_o),
    .lock_o(lock_o), .err_count_o(err_count_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One cadence window: pulse at c=0 (8 cycles), optional extra pulse at c=20
  task automatic run_period(input int len, input bit extra, output int nsec,
                            output int first_unlock, output bit lock_end);
    nsec = 0;
    first_unlock = -1;
    for (int c = 0; c < len; c++) begin
      data_i = (c < 8) || (extra && c >= 20 && c < 28);
      tick;
      if (sec_pulse_o) nsec++;
      if (!lock_o && first_unlock < 0) first_unlock = c;
    end
    lock_end = lock_o;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; data_i = 1'b0; inverted_i = 1'b0;
    tick; tick;
    if (data_o !== 1'b0) begin errors++; $display("FAIL reset_data: got %b expected 0", data_o); end
    checks++;
    if (rise_o !== 1'b0 || fall_o !== 1'b0) begin errors++; $display("FAIL reset_edges: got %b%b expected 00", rise_o, fall_o); end
    checks++;
    if (sec_pulse_o !== 1'b0) begin errors++; $display("FAIL reset_sec: got %b expected 0", sec_pulse_o); end
    checks++;
    if (lock_o !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b expected 0", lock_o); end
    checks++;
    if (err_count_o !== 8'h00) begin errors++; $display("FAIL reset_err: got %0d expected 0", err_count_o); end
    checks++;
    rst_ni = 1'b1;
    tick; tick;
  endtask

  task automatic test_step;
    data_i = 1'b1;
    repeat (5) tick;
    if (data_o !== 1'b0) begin errors++; $display("FAIL step_early: got %b expected 0", data_o); end
    checks++;
    tick;
    if (data_o !== 1'b1) begin errors++; $display("FAIL step_data: got %b expected 1", data_o); end
    checks++;
    if (rise_o !== 1'b0) begin errors++; $display("FAIL step_rise_early: got %b expected 0", rise_o); end
    checks++;
    tick;
    if (rise_o !== 1'b1) begin errors++; $display("FAIL step_rise: got %b expected 1", rise_o); end
    checks++;
    tick;
    if (rise_o !== 1'b0) begin errors++; $display("FAIL step_rise_width: got %b expected 0", rise_o); end
    checks++;
  endtask

  task automatic test_glitch;
    bit saw_edge = 1'b0;
    bit saw_low  = 1'b0;
    repeat (3) begin
      data_i = 1'b0;
      repeat (2) begin tick; saw_edge |= rise_o | fall_o; saw_low |= ~data_o; end
      data_i = 1'b1;
      repeat (8) begin tick; saw_edge |= rise_o | fall_o; saw_low |= ~data_o; end
    end
    if (saw_low !== 1'b0) begin errors++; $display("FAIL glitch_data: got low=%b expected 0", saw_low); end
    checks++;
    if (saw_edge !== 1'b0) begin errors++; $display("FAIL glitch_edges: got %b expected 0", saw_edge); end
    checks++;
    // Let the period counter saturate so the cadence test starts from a clean anchor
    data_i = 1'b0;
    repeat (250) tick;
    if (data_o !== 1'b0) begin errors++; $display("FAIL idle_data: got %b expected 0", data_o); end
    checks++;
`ifdef MSF_INPUT_STATS_EN
    if (err_count_o !== 8'd1) begin errors++; $display("FAIL idle_err: got %0d expected 1", err_count_o); end
`else
    if (err_count_o !== 8'd0) begin errors++; $display("FAIL idle_err: got %0d expected 0", err_count_o); end
`endif
    checks++;
  endtask

  task automatic test_cadence;
    int nsec, fu;
    bit lk;
    for (int w = 1; w <= 5; w++) begin
      run_period(100, 1'b1, nsec, fu, lk);
      if (nsec !== 1) begin errors++; $display("FAIL cadence_sec_w%0d: got %0d expected 1", w, nsec); end
      checks++;
      if (w == 3 || w == 1) begin
        if (lk !== 1'b0) begin errors++; $display("FAIL cadence_nolock_w%0d: got %b expected 0", w, lk); end
        checks++;
      end
      if (w == 4) begin
        if (lk !== 1'b1) begin errors++; $display("FAIL cadence_lock: got %b expected 1", lk); end
        checks++;
      end
      if (w == 5) begin
        if (fu !== -1) begin errors++; $display("FAIL cadence_hold: got unlock at %0d expected none", fu); end
        checks++;
      end
    end
  endtask

  task automatic test_timeout;
    int nsec, fu;
    bit lk;
    logic [7:0] e0;
    e0 = err_count_o;
    run_period(260, 1'b0, nsec, fu, lk);
    if (fu !== 207) begin errors++; $display("FAIL timeout_unlock: got cycle %0d expected 207", fu); end
    checks++;
`ifdef MSF_INPUT_STATS_EN
    if (err_count_o !== e0 + 8'd1) begin errors++; $display("FAIL timeout_err: got %0d expected %0d", err_count_o, e0 + 8'd1); end
    checks++;
`endif
    run_period(100, 1'b0, nsec, fu, lk);
    if (nsec !== 1) begin errors++; $display("FAIL timeout_anchor_sec: got %0d expected 1", nsec); end
    checks++;
    if (lk !== 1'b0) begin errors++; $display("FAIL timeout_anchor_lock: got %b expected 0", lk); end
    checks++;
`ifdef MSF_INPUT_STATS_EN
    if (err_count_o !== e0 + 8'd1) begin errors++; $display("FAIL timeout_anchor_err: got %0d expected %0d", err_count_o, e0 + 8'd1); end
`else
    if (err_count_o !== 8'd0) begin errors++; $display("FAIL timeout_anchor_err: got %0d expected 0", err_count_o); end
`endif
    checks++;
  endtask

  task automatic test_relock_after_late;
    int nsec, fu;
    bit lk;
    logic [7:0] e0;
    for (int w = 1; w <= 3; w++) run_period(100, 1'b0, nsec, fu, lk);
    if (lk !== 1'b1) begin errors++; $display("FAIL relock_initial: got %b expected 1", lk); end
    checks++;
    e0 = err_count_o;
    run_period(150, 1'b0, nsec, fu, lk);
    run_period(100, 1'b0, nsec, fu, lk);
    if (nsec !== 1) begin errors++; $display("FAIL late_sec: got %0d expected 1", nsec); end
    checks++;
    if (fu !== 7) begin errors++; $display("FAIL late_unlock: got cycle %0d expected 7", fu); end
    checks++;
`ifdef MSF_INPUT_STATS_EN
    if (err_count_o !== e0 + 8'd1) begin errors++; $display("FAIL late_err: got %0d expected %0d", err_count_o, e0 + 8'd1); end
    checks++;
`endif
    for (int w = 1; w <= 3; w++) begin
      run_period(100, 1'b0, nsec, fu, lk);
      if (w == 2) begin
        if (lk !== 1'b0) begin errors++; $display("FAIL late_relock_early: got %b expected 0", lk); end
        checks++;
      end
    end
    if (lk !== 1'b1) begin errors++; $display("FAIL late_relock: got %b expected 1", lk); end
    checks++;
  endtask

  task automatic test_reset_mid;
    rst_ni = 1'b0;
    #1;
    if (lock_o !== 1'b0 || data_o !== 1'b0 || sec_pulse_o !== 1'b0 || rise_o !== 1'b0 || fall_o !== 1'b0)
      begin errors++; $display("FAIL midreset_outputs: got lock=%b data=%b sec=%b rise=%b fall=%b expected all 0",
                               lock_o, data_o, sec_pulse_o, rise_o, fall_o); end
    checks++;
    if (err_count_o !== 8'h00) begin errors++; $display("FAIL midreset_err: got %0d expected 0", err_count_o); end
    checks++;
    inverted_i = 1'b1;
    data_i = 1'b0;
    tick; tick;
    rst_ni = 1'b1;
    repeat (6) tick;
    if (data_o !== 1'b1) begin errors++; $display("FAIL inverted_data: got %b expected 1", data_o); end
    checks++;
  endtask

  initial begin
    test_reset;
    test_step;
    test_glitch;
    test_cadence;
    test_timeout;
    test_relock_after_late;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
